// File: rtl/imul_seq_ctrl_pkg.sv
// Shared definitions for the sequential radix-4 multiplier: FSM encoding and
// iteration-count helpers used to size the digit counter.
package imul_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_SIZE  = 16;
  localparam int unsigned DEFAULT_ITERS = DEFAULT_SIZE / 2;

  // One radix-4 digit of B is consumed per clock.
  function automatic int unsigned iter_count(input int unsigned size);
    return size / 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/imul_pp_mux4.sv
// Radix-4 partial product: A times a 2-bit digit, selected from {0, A, 2A, 3A}.
module imul_pp_mux4 #(
  parameter int unsigned SIZE = 16
) (
  input  logic [SIZE-1:0] a,
  input  logic [1:0]      digit,
  output logic [SIZE+1:0] pp
);

  logic [SIZE+1:0] a_x1;
  logic [SIZE+1:0] a_x2;
  logic [SIZE+1:0] a_x3;

  assign a_x1 = {2'b00, a};
  assign a_x2 = {1'b0, a, 1'b0};
  assign a_x3 = a_x2 + a_x1;

  always_comb begin
    pp = '0;
    case (digit)
      2'd0:    pp = '0;
      2'd1:    pp = a_x1;
      2'd2:    pp = a_x2;
      2'd3:    pp = a_x3;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/imul_seq_ctrl.sv
// Sequential radix-4 unsigned multiplier: one shared SIZE+2-bit adder iterated
// SIZE/2 times, result presented through a valid/ready handshake.
module imul_seq_ctrl
  import imul_seq_ctrl_pkg::*;
#(
  parameter int unsigned SIZE = DEFAULT_SIZE
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStart,
  input  logic [SIZE-1:0]   iA,
  input  logic [SIZE-1:0]   iB,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oValid,
  output logic [2*SIZE-1:0] oResult
);

  localparam int unsigned ITERS = iter_count(SIZE);
  localparam int unsigned CW    = cnt_width(ITERS);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

  if ((SIZE < 4) || ((SIZE % 2) != 0)) begin : g_size_check
    $error("imul_seq_ctrl: SIZE must be even and >= 4");
  end

  state_e          state;
  logic [SIZE-1:0] a_r;
  logic [SIZE-1:0] b_r;
  logic [SIZE+1:0] h_r;
  logic [SIZE-1:0] l_r;
  logic [CW-1:0]   cnt;

  logic [SIZE+1:0] pp;
  logic [SIZE+1:0] sum;
  logic [SIZE+1:0] h_next;
  logic [SIZE-1:0] l_next;

  imul_pp_mux4 #(
    .SIZE (SIZE)
  ) u_pp_mux (
    .a     (a_r),
    .digit (b_r[1:0]),
    .pp    (pp)
  );

  // H + pp peaks at 4*(2^SIZE-1), so SIZE+2 bits never overflow.
  assign sum    = h_r + pp;
  assign h_next = {2'b00, sum[SIZE+1:2]};
  assign l_next = {sum[1:0], l_r[SIZE-1:2]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      h_r     <= '0;
      l_r     <= '0;
      cnt     <= '0;
      oBusy   <= 1'b0;
      oValid  <= 1'b0;
      oResult <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            a_r   <= iA;
            b_r   <= iB;
            h_r   <= '0;
            l_r   <= '0;
            cnt   <= '0;
            oBusy <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          h_r <= h_next;
          l_r <= l_next;
          b_r <= b_r >> 2;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            oResult <= {h_next[SIZE-1:0], l_next};
            oValid  <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A start arriving alongside the handshake is dropped, not queued.
          if (iReady) begin
            oValid <= 1'b0;
            oBusy  <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          oValid <= 1'b0;
          oBusy  <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imul_seq_ctrl.sv
// Self-checking bench for imul_seq_ctrl (SIZE=16): vector table plus corner sequences.
module tb_imul_seq_ctrl;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        iReady;
  logic        oBusy;
  logic        oValid;
  logic [31:0] oResult;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  imul_seq_ctrl #(
    .SIZE (16)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iA      (iA),
    .iB      (iB),
    .iReady  (iReady),
    .oBusy   (oBusy),
    .oValid  (oValid),
    .oResult (oResult)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit track);
    @(negedge Clock);
    iA     = a;
    iB     = b;
    iStart = 1'b1;
    if (track) sb.push_back(32'(a) * 32'(b));
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!oValid && n < 40) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic collect(input string name, output logic [31:0] exp);
    exp = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    check(name, oResult, exp);
  endtask

  task automatic handshake(input string name);
    iReady = 1'b1;
    @(negedge Clock);
    iReady = 1'b0;
    check({name, "_valid_drop"}, oValid, 0);
    check({name, "_busy_drop"}, oBusy, 0);
  endtask

  initial begin
    int          n;
    int          bad;
    logic [31:0] exp;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h1234, 16'h5678, 32'h0626_0060};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h0000_0000};
    vecs[4] = '{16'hABCD, 16'h0000, 32'h0000_0000};
    vecs[5] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};

    Reset  = 1'b1;
    iStart = 1'b0;
    iA     = '0;
    iB     = '0;
    iReady = 1'b0;
    #2;
    check("reset_busy", oBusy, 0);
    check("reset_valid", oValid, 0);
    check("reset_result", oResult, 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Table vectors: scoreboard holds the table's expected product.
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, 1'b0);
      sb.push_back(vecs[i].exp);
      check($sformatf("vec%0d_busy", i), oBusy, 1);
      wait_valid(n);
      check($sformatf("vec%0d_latency", i), n, 8);
      collect($sformatf("vec%0d_result", i), exp);
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: result must hold for 20 cycles with iReady low.
    start_op(16'h00C3, 16'h0F0F, 1'b1);
    wait_valid(n);
    check("bp_latency", n, 8);
    collect("bp_result", exp);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (oValid !== 1'b1 || oResult !== exp || oBusy !== 1'b1) bad++;
    end
    check("bp_stable_cycles_bad", bad, 0);
    handshake("bp");

    // Starts during RUN and operand changes after acceptance are ignored.
    start_op(16'h00FF, 16'h0101, 1'b1);
    @(negedge Clock);
    iA     = 16'h1111;
    iB     = 16'h2222;
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    iA     = 16'hFFFF;
    iB     = 16'h7777;
    check("run_start_busy", oBusy, 1);
    wait_valid(n);
    check("run_start_latency", n, 6);
    collect("run_start_result", exp);
    handshake("run_start");
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      if (oValid !== 1'b0 || oBusy !== 1'b0) bad++;
    end
    check("no_second_result", bad, 0);
    check("result_retained", oResult, 32'h0000_FFFF);

    // Asynchronous reset in the middle of RUN clears outputs immediately.
    start_op(16'h0BAD, 16'h0F00, 1'b0);
    repeat (3) @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_busy", oBusy, 0);
    check("async_rst_valid", oValid, 0);
    check("async_rst_result", oResult, 0);
    @(negedge Clock);
    Reset = 1'b0;
    start_op(16'h0BAD, 16'h0F00, 1'b1);
    wait_valid(n);
    check("post_rst_latency", n, 8);
    collect("post_rst_result", exp);
    handshake("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imul_seq_ctrl.md
Name: imul_seq_ctrl

Overview:
Sequential radix-4 multiplier controller. It reuses one SIZE+2-bit adder and a 2-bit partial-product mux over SIZE/2 cycles instead of the full combinational array.
- Accepts an operand pair on a start pulse.
- Iterates one 2-bit digit of B per clock.
- Presents the 2*SIZE-bit product with a valid/ready handshake.
- Serves as the low-area multiply engine next to the combinational IMUL blocks.

Parameters:
SIZE, 16, operand width. Must be even and >= 4. Iteration count is SIZE/2.

Ports:
Clock  input  1  system clock; all state updates on the rising edge
Reset  input  1  asynchronous, active-high reset
iStart  input  1  request; sampled only in IDLE
iA  input  SIZE  multiplicand; captured when start is accepted
iB  input  SIZE  multiplier; captured when start is accepted
iReady  input  1  consumer accepts the result when high while oValid is high
oBusy  output  1  high in RUN or DONE
oValid  output  1  result valid; high only in DONE
oResult  output  2*SIZE  unsigned product A*B

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, all internal registers=0, oBusy=0, oValid=0, oResult=0. Reset asserted mid-operation aborts the operation with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - iStart=1 at an edge: latch A_r=iA, B_r=iB; H=0 (SIZE+2 bits); L=0 (SIZE bits); cnt=0; go to RUN.
  - iStart=0: stay in IDLE.
- RUN, each edge:
  - pp = A_r * B_r[1:0], from a mux over {0, A, A<<1, (A<<1)+A}, SIZE+2 bits.
  - sum = H + pp, SIZE+2 bits; no overflow is possible since max is 4*(2^SIZE-1).
  - H <= sum >> 2.
  - L <= {sum[1:0], L[SIZE-1:2]}.
  - B_r <= B_r >> 2; cnt <= cnt + 1.
  - At cnt == SIZE/2-1: go to DONE, and the same edge loads oResult = {H_next[SIZE-1:0], L_next}.
- Latency: start accepted at edge k; oValid=1 after edge k+SIZE/2 (8 cycles for SIZE=16).
- DONE:
  - oValid=1; oResult held stable.
  - iReady=1 at an edge: go to IDLE, oValid drops next cycle.
  - iReady=0: hold indefinitely (backpressure).
- iStart is ignored while oBusy=1: no queueing and no error flag.
  - iStart and iReady high in the same DONE cycle: the handshake completes and the start is dropped. The requester must re-assert iStart in IDLE.
  - Minimum request spacing: SIZE/2+2 cycles.
- oResult keeps the last product after returning to IDLE until the next completion overwrites it.
- Operand changes on iA/iB after acceptance have no effect.
- cnt width: clog2(SIZE/2), or 1 bit minimum.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and a localparam for the iteration count SIZE/2.
- One sub-module: imul_pp_mux4 (#SIZE). Combinational A x 2-bit digit to SIZE+2-bit partial product. Instantiated once.
- Adder, shift registers and FSM live in imul_seq_ctrl.

Test Plan:
- SIZE=16; iA=3, iB=5, iStart for 1 cycle, iReady=1 -> oValid high after exactly 8 edges, oResult=0x0000000F, oBusy low one cycle later.
- iA=0xFFFF, iB=0xFFFF -> oResult=0xFFFE0001 (max-value carry path). iA=0x1234, iB=0x5678 -> oResult=0x06260060.
- iA=0, iB=0xABCD, and iA=0xABCD, iB=0 -> oResult=0 in both cases, still 8-cycle latency.
- Backpressure: hold iReady=0 for 20 cycles after oValid -> oValid and oResult stable throughout; iReady=1 for one edge -> IDLE.
- iStart pulses during RUN with different operands, then a change to iA/iB after acceptance -> original product unaffected, oBusy stays high, no second result produced.
- Assert Reset at RUN cycle 4 -> oBusy=0, oValid=0, oResult=0 immediately (asynchronously). A new start afterwards -> correct product.
